// File: rtl/tetris_pkg.sv
// Shared constants and types for the tetris drawing datapath.
package tetris_pkg;
    localparam int CELL_W = 64;
    localparam int CELL_H = 24;
    localparam int SCR_W  = 640;
    localparam int SCR_H  = 480;

    localparam logic [8:0] BG    = 9'd0;
    localparam logic [8:0] PIECE = 9'b111_000_111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_e;
endpackage

// File: rtl/box_fill_engine_raster_counter.sv
// Raster-order column/row counter over a W x H box with clear, enable and last flag.
module raster_counter #(
    parameter int W   = 64,
    parameter int H   = 24,
    parameter int CXW = (W > 1) ? $clog2(W) : 1,
    parameter int CYW = (H > 1) ? $clog2(H) : 1
) (
    input  logic           CLOCK_50,
    input  logic           resetn,
    input  logic           clear,
    input  logic           en,
    output logic [CXW-1:0] cx,
    output logic [CYW-1:0] cy,
    output logic           last
);
    localparam logic [CXW-1:0] CX_MAX = CXW'(W - 1);
    localparam logic [CYW-1:0] CY_MAX = CYW'(H - 1);

    // Explicit wrap compares keep non-power-of-two box sizes correct.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            cx <= '0;
            cy <= '0;
        end else if (clear) begin
            cx <= '0;
            cy <= '0;
        end else if (en) begin
            if (cx == CX_MAX) begin
                cx <= '0;
                if (cy == CY_MAX) cy <= '0;
                else              cy <= cy + 1'b1;
            end else begin
                cx <= cx + 1'b1;
            end
        end
    end

    assign last = (cx == CX_MAX) && (cy == CY_MAX);
endmodule

// File: rtl/box_fill_engine.sv
// Streams a clipped BOX_W x BOX_H rectangle of one colour into the framebuffer port.
// Handshake: start is taken when busy=0; a pixel is written on a cycle with plot && fb_ready.
module box_fill_engine
    import tetris_pkg::*;
#(
    parameter int BOX_W = tetris_pkg::CELL_W,
    parameter int BOX_H = tetris_pkg::CELL_H,
    parameter int XW    = 10,
    parameter int YW    = 9,
    parameter int CW    = 9,
    parameter int SCR_W = tetris_pkg::SCR_W,
    parameter int SCR_H = tetris_pkg::SCR_H
) (
    input  logic          CLOCK_50,
    input  logic          resetn,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [CW-1:0] color,
    output logic          busy,
    output logic          done,
    output logic          plot,
    output logic [XW-1:0] px,
    output logic [YW-1:0] py,
    output logic [CW-1:0] pcolor,
    input  logic          fb_ready
);
    localparam int CXW = (BOX_W > 1) ? $clog2(BOX_W) : 1;
    localparam int CYW = (BOX_H > 1) ? $clog2(BOX_H) : 1;
    localparam logic [XW:0] X_LIM = (XW + 1)'(SCR_W);
    localparam logic [YW:0] Y_LIM = (YW + 1)'(SCR_H);

    fill_state_e    state;
    logic [XW-1:0]  bx;
    logic [YW-1:0]  by;
    logic [CW-1:0]  bcol;
    logic [CXW-1:0] cx;
    logic [CYW-1:0] cy;
    logic           last;
    logic [XW:0]    sum_x;
    logic [YW:0]    sum_y;
    logic           on_screen;
    logic           accept;
    logic           advance;

    // One extra bit so boxes hanging past the coordinate range still clip.
    assign sum_x     = {1'b0, bx} + (XW + 1)'(cx);
    assign sum_y     = {1'b0, by} + (YW + 1)'(cy);
    assign on_screen = (sum_x < X_LIM) && (sum_y < Y_LIM);

    assign accept  = start && (state != FILL);
    assign advance = (state == FILL) && (!on_screen || fb_ready);

    assign busy   = (state == FILL);
    assign done   = (state == DONE);
    assign plot   = (state == FILL) && on_screen;
    assign px     = sum_x[XW-1:0];
    assign py     = sum_y[YW-1:0];
    assign pcolor = bcol;

    raster_counter #(
        .W   (BOX_W),
        .H   (BOX_H),
        .CXW (CXW),
        .CYW (CYW)
    ) u_raster (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .clear    (accept),
        .en       (advance),
        .cx       (cx),
        .cy       (cy),
        .last     (last)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            bx    <= '0;
            by    <= '0;
            bcol  <= '0;
        end else begin
            if (accept) begin
                bx   <= x0;
                by   <= y0;
                bcol <= color;
            end
            case (state)
                IDLE:    if (start) state <= FILL;
                FILL:    if (advance && last) state <= DONE;
                DONE:    state <= start ? FILL : IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_box_fill_engine.sv
// Randomized bench for box_fill_engine against a pixel-index reference model.
module tb_box_fill_engine;
    localparam int BOX_W = 64;
    localparam int BOX_H = 24;
    localparam int NPIX  = BOX_W * BOX_H;
    localparam int SCR_W = 640;
    localparam int SCR_H = 480;
    localparam int BOUND = 6000;

    logic       CLOCK_50 = 1'b0;
    logic       resetn   = 1'b0;
    logic       start    = 1'b0;
    logic       fb_ready = 1'b1;
    logic [9:0] x0       = '0;
    logic [8:0] y0       = '0;
    logic [8:0] color    = '0;
    logic       busy, done, plot;
    logic [9:0] px;
    logic [8:0] py;
    logic [8:0] pcolor;

    box_fill_engine dut (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .start    (start),
        .x0       (x0),
        .y0       (y0),
        .color    (color),
        .busy     (busy),
        .done     (done),
        .plot     (plot),
        .px       (px),
        .py       (py),
        .pcolor   (pcolor),
        .fb_ready (fb_ready)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: box described by origin, colour and a linear pixel index.
    int          m_state = 0;   // 0 idle, 1 filling, 2 done pulse
    int          m_idx   = 0;
    int          m_bx    = 0;
    int          m_by    = 0;
    logic [8:0]  m_col   = '0;
    logic [27:0] exp_q[$];
    int          wr_cnt  = 0;
    logic [27:0] last_wr = '0;
    logic        prev_plot = 1'b0;
    logic [27:0] prev_pix  = '0;

    task automatic m_accept();
        int ex, ey;
        chk("queue_empty_at_accept", exp_q.size(), 0);
        exp_q.delete();
        m_bx = x0; m_by = y0; m_col = color; m_idx = 0; m_state = 1;
        for (int i = 0; i < NPIX; i++) begin
            ex = m_bx + i % BOX_W;
            ey = m_by + i / BOX_W;
            if (ex < SCR_W && ey < SCR_H) exp_q.push_back({ex[9:0], ey[8:0], m_col});
        end
    endtask

    // Inputs seen at a falling edge are the ones sampled by the rising edge just passed.
    always @(negedge CLOCK_50) begin
        int ex, ey;
        logic [27:0] e;
        if (!resetn) begin
            m_state = 0; m_idx = 0; exp_q.delete(); prev_plot = 1'b0;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_plot", plot, 0);
            chk("rst_px", px, 0);
            chk("rst_py", py, 0);
            chk("rst_pcolor", pcolor, 0);
        end else begin
            if (prev_plot && fb_ready) begin
                wr_cnt++;
                last_wr = prev_pix;
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_pixel", prev_pix, e);
                end
            end
            case (m_state)
                0: if (start) m_accept();
                1: begin
                    ex = m_bx + m_idx % BOX_W;
                    ey = m_by + m_idx / BOX_W;
                    if (!(ex < SCR_W && ey < SCR_H) || fb_ready) begin
                        m_idx++;
                        if (m_idx == NPIX) m_state = 2;
                    end
                end
                default: if (start) m_accept(); else m_state = 0;
            endcase
            chk("busy", busy, (m_state == 1));
            chk("done", done, (m_state == 2));
            if (m_state == 1) begin
                ex = m_bx + m_idx % BOX_W;
                ey = m_by + m_idx / BOX_W;
                chk("plot", plot, (ex < SCR_W && ey < SCR_H));
                chk("px", px, ex[9:0]);
                chk("py", py, ey[8:0]);
                chk("pcolor", pcolor, m_col);
            end else begin
                chk("plot_idle", plot, 0);
            end
            prev_plot = plot;
            prev_pix  = {px, py, pcolor};
        end
    end

    task automatic step();
        @(negedge CLOCK_50);
        #1;
    endtask

    task automatic launch(input int xx, input int yy, input logic [8:0] cc);
        x0 = 10'(xx); y0 = 9'(yy); color = cc; start = 1'b1; fb_ready = 1'b1;
    endtask

    // Runs one box to its done pulse; start must already be driven high.
    task automatic run_box(input bit rnd, input bit inject, input int exp_wr,
                           input int exp_lat, input logic [27:0] exp_last);
        int k;
        k = 0;
        wr_cnt = 0;
        while (1) begin
            step();
            k++;
            if (done || k >= BOUND) break;
            if (k == 1) begin
                start = 1'b0;
                chk("busy_first_cycle", busy, 1);
                x0 = 10'($urandom_range(0, 1023));
                color = 9'($urandom_range(0, 511));
            end
            if (inject && k == 300) begin start = 1'b1; x0 = 10'd300; color = 9'h155; end
            if (inject && k == 301) start = 1'b0;
            fb_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        chk("done_within_bound", (k < BOUND), 1);
        if (exp_lat > 0) chk("done_latency", k, exp_lat);
        if (exp_wr >= 0) chk("write_count", wr_cnt, exp_wr);
        chk("all_writes_seen", exp_q.size(), 0);
        if (exp_wr > 0) chk("last_write", last_wr, exp_last);
        fb_ready = 1'b1;
    endtask

    initial begin
        repeat (3) step();
        resetn = 1'b1;
        step();

        launch(0, 0, 9'h1C7);
        run_box(0, 0, NPIX, NPIX + 1, {10'd63, 9'd23, 9'h1C7});
        step();

        launch(576, 456, 9'h0F0);
        run_box(0, 0, NPIX, NPIX + 1, {10'd639, 9'd479, 9'h0F0});
        step();

        launch(100, 200, 9'h03A);
        run_box(1, 0, NPIX, 0, {10'd163, 9'd223, 9'h03A});
        step();

        launch(600, 470, 9'h1FF);
        run_box(0, 0, 400, NPIX + 1, {10'd639, 9'd479, 9'h1FF});
        step();

        for (int r = 0; r < 3; r++) begin
            launch($urandom_range(0, 1023), $urandom_range(0, 511), 9'($urandom_range(0, 511)));
            run_box(1, 0, -1, 0, '0);
            step();
        end

        launch(1000, 500, 9'h011);
        run_box(0, 0, 0, NPIX + 1, '0);
        step();

        // Start during the fill is ignored; start in the done cycle chains.
        launch(10, 20, 9'h0AA);
        run_box(0, 1, NPIX, NPIX + 1, {10'd73, 9'd43, 9'h0AA});
        launch(200, 100, 9'h111);
        run_box(0, 0, NPIX, NPIX + 1, {10'd263, 9'd123, 9'h111});
        step();

        // Abort mid-fill with reset, then draw a fresh box.
        launch(0, 0, 9'h1C7);
        wr_cnt = 0;
        for (int k = 0; k < BOUND; k++) begin
            step();
            start = 1'b0;
            if (wr_cnt >= 700) break;
        end
        chk("reached_pixel_700", wr_cnt, 700);
        resetn = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_plot", plot, 0);
        chk("async_px", px, 0);
        chk("async_py", py, 0);
        chk("async_pcolor", pcolor, 0);
        repeat (2) step();
        resetn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("no_done_after_abort", done, 0);
        end
        launch(320, 240, 9'h0C3);
        run_box(0, 0, NPIX, NPIX + 1, {10'd383, 9'd263, 9'h0C3});
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/box_fill_engine.md
Name: box_fill_engine

Overview:
- Responder side of the painter start/busy/done handshake: accepts one box-draw command (origin, colour) and streams every pixel of a BOX_W x BOX_H rectangle into the framebuffer write port in raster order.
- Sits between the top-level draw sequencer and the VGA framebuffer adapter.
- Reports completion with a single-cycle done pulse while busy is already low.

Parameters:
- BOX_W, 64, box width in pixels.
- BOX_H, 24, box height in pixels.
- XW, 10, pixel x coordinate width.
- YW, 9, pixel y coordinate width.
- CW, 9, colour width (3:3:3 RGB).
- SCR_W, 640, screen width; pixels with x >= SCR_W are clipped.
- SCR_H, 480, screen height; pixels with y >= SCR_H are clipped.

Ports:
- CLOCK_50  in   1   system clock.
- resetn    in   1   reset, asynchronous, active-low.
- start     in   1   command strobe; accepted only while busy=0.
- x0        in   XW  box origin x; sampled with start.
- y0        in   YW  box origin y; sampled with start.
- color     in   CW  fill colour; sampled with start.
- busy      out  1   high from the cycle after acceptance through the last pixel.
- done      out  1   one-cycle completion pulse.
- plot      out  1   pixel write valid.
- px        out  XW  pixel x.
- py        out  YW  pixel y.
- pcolor    out  CW  pixel colour.
- fb_ready  in   1   framebuffer accepts the pixel this cycle. A write occurs when plot && fb_ready.

Behaviour:
- Reset (asynchronous): state IDLE. busy=0, done=0, plot=0, px=0, py=0, pcolor=0. Counters and latched command registers cleared. Reset mid-fill aborts immediately and produces no done.
- States: IDLE, FILL, DONE.
- IDLE:
  - busy=0, done=0, plot=0.
  - start=1 at edge N: latch x0/y0/color, cx=0, cy=0, go to FILL.
- FILL:
  - busy=1, done=0.
  - px = bx+cx and py = by+cy, each computed one bit wider for the clip compare, then truncated.
  - pcolor = latched colour.
  - plot = 1 only when the pixel is on-screen (x < SCR_W and y < SCR_H); plot may depend combinationally on state and counters.
  - Counters advance when (plot && fb_ready) or when the pixel is clipped. Clipped pixels cost one cycle each and need no fb_ready.
  - With fb_ready=0 on an on-screen pixel, px/py/pcolor/plot hold.
  - Advance order: cx increments to BOX_W-1, then wraps to 0 and cy increments. On the advance of (BOX_W-1, BOX_H-1), go to DONE.
- DONE:
  - Exactly one cycle: busy=0, done=1, plot=0. Then IDLE.
  - A start sampled during the DONE cycle is accepted: transition directly to FILL, done still pulses that cycle.
- start while busy=1 is ignored; the latched command is unaffected.
- Latency with fb_ready held high and no clipping:
  - start sampled at edge N.
  - First pixel (x0, y0) valid in cycle N+1.
  - Last pixel in cycle N+BOX_W*BOX_H (N+1536 at defaults).
  - done in cycle N+1537.
- Counter widths: cx is clog2(BOX_W) bits, cy is clog2(BOX_H) bits; compare against BOX_W-1 / BOX_H-1, never rely on natural overflow.
- x0/y0/color changes after acceptance have no effect.

Decomposition:
- Shared package (tetris_pkg):
  - CELL_W=64, CELL_H=24, SCR_W, SCR_H.
  - Colour constants: BG=0, PIECE=9'b111_000_111.
  - State enum {IDLE, FILL, DONE}.
- One natural sub-module: raster_counter (cx/cy with enable, wrap, and last flag). The FSM and clipping stay in the top module.

Test Plan:
- Reset, then start with x0=0, y0=0, color=0x1C7, fb_ready=1 → 1536 writes covering (0..63, 0..23), all pcolor=0x1C7. done pulses exactly once in cycle N+1537 with busy=0.
- Box at x0=576, y0=456 → last write at (639, 479). Total writes = 1536, done timing unchanged.
- fb_ready toggled pseudo-randomly → each on-screen pixel is written exactly once, in raster order. px/py/pcolor stay stable while fb_ready=0. done follows the final accepted write by 1 cycle.
- Clipping: x0=600, y0=470 → only pixels x<640, y<480 are written (40x10=400 writes). done still arrives 1537 cycles after start with fb_ready=1.
- start re-asserted mid-fill with different x0/color → ignored, original box completes unchanged. start asserted in the DONE cycle → new fill begins next cycle with no IDLE gap.
- resetn pulsed low at pixel 700 → outputs go to reset values immediately, no done pulse. A following start draws a full fresh box.
